// File: rtl/frame_tx_sched.sv
// Purpose: per-frame timing scheduler; one frame counter drives header/scope strobe,
//          fast optical switch gate and second IM gate for N-frame or continuous bursts.
// Latency: all outputs registered, lagging the frame position by exactly 1 clock.
// Backpressure: none; go while busy and cfg changes while busy are ignored, stop ends
//               the run only after the current frame completes.
//
// Ports:
//   clk, rstn           DAC-domain clock, asynchronous active-low reset
//   go, stop            single-cycle start (latches cfg) / end-after-current-frame request
//   cfg_*               frame period, header length, switch/IM windows, frame count, trigger mode
//   trig                asynchronous external start trigger (rising edge used)
//   hdr_vld, fast_opsw, second_im, frame_start   per-frame gates and strobes
//   busy, done, frames_sent                      run status
module frame_tx_sched #(
  parameter int CNT_W       = 16,
  parameter int NFR_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             go,
  input  logic             stop,
  input  logic             cfg_use_trig,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_hdr_len,
  input  logic [CNT_W-1:0] cfg_sw_on,
  input  logic [CNT_W-1:0] cfg_sw_off,
  input  logic [CNT_W-1:0] cfg_im_on,
  input  logic [CNT_W-1:0] cfg_im_off,
  input  logic [NFR_W-1:0] cfg_num_frames,
  input  logic             trig,
  output logic             hdr_vld,
  output logic             fast_opsw,
  output logic             second_im,
  output logic             frame_start,
  output logic             busy,
  output logic             done,
  output logic [NFR_W-1:0] frames_sent
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_TRIG = 2'd1,
    ST_RUN       = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MIN_PERIOD = CNT_W'(2);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] pos_q, pos_d;
  logic [NFR_W-1:0] frames_q, frames_d;
  logic             stop_flag_q, stop_flag_d;
  logic             latch_cfg;

  // Configuration captured at go; held constant for the whole run.
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] hdr_len_q;
  logic [CNT_W-1:0] sw_on_q;
  logic [CNT_W-1:0] sw_off_q;
  logic [CNT_W-1:0] im_on_q;
  logic [CNT_W-1:0] im_off_q;
  logic [NFR_W-1:0] num_frames_q;

  logic [SYNC_STAGES-1:0] trig_sync_q;
  logic                   trig_prev_q;
  logic                   trig_rise;

  logic hdr_q, sw_q, im_q, fs_q, busy_q, done_q;

  logic wrap;
  logic last_frame;
  logic run;

  assign trig_rise  = trig_sync_q[SYNC_STAGES-1] & ~trig_prev_q;
  assign run        = (state_q == ST_RUN);
  assign wrap       = (pos_q == (period_q - CNT_W'(1)));
  // frames_q counts completed frames, so +1 is the frame currently ending.
  assign last_frame = (num_frames_q != '0) && ((frames_q + NFR_W'(1)) == num_frames_q);

  // trig is asynchronous to clk: plain flop chain before any edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      trig_sync_q <= '0;
      trig_prev_q <= 1'b0;
    end else begin
      trig_sync_q <= {trig_sync_q[SYNC_STAGES-2:0], trig};
      trig_prev_q <= trig_sync_q[SYNC_STAGES-1];
    end
  end

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    frames_d    = frames_q;
    stop_flag_d = stop_flag_q;
    latch_cfg   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // go wins over a simultaneous stop; stop has no meaning here.
        if (go) begin
          latch_cfg   = 1'b1;
          frames_d    = '0;
          stop_flag_d = 1'b0;
          pos_d       = '0;
          state_d     = cfg_use_trig ? ST_WAIT_TRIG : ST_RUN;
        end
      end
      ST_WAIT_TRIG: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (trig_rise) begin
          pos_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          stop_flag_d = 1'b1;
        end
        if (wrap) begin
          pos_d = '0;
          if (frames_q != '1) begin
            frames_d = frames_q + NFR_W'(1);
          end
          // A stop landing exactly on the wrap ends here as well, so it
          // never starts an extra frame.
          if (last_frame || stop_flag_q || stop) begin
            stop_flag_d = 1'b0;
            state_d     = ST_IDLE;
          end
        end else begin
          pos_d = pos_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      pos_q       <= '0;
      frames_q    <= '0;
      stop_flag_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      frames_q    <= frames_d;
      stop_flag_q <= stop_flag_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      period_q     <= '0;
      hdr_len_q    <= '0;
      sw_on_q      <= '0;
      sw_off_q     <= '0;
      im_on_q      <= '0;
      im_off_q     <= '0;
      num_frames_q <= '0;
    end else if (latch_cfg) begin
      // Periods of 0 or 1 would never wrap sensibly; clamp to 2.
      period_q     <= (cfg_period < MIN_PERIOD) ? MIN_PERIOD : cfg_period;
      hdr_len_q    <= cfg_hdr_len;
      sw_on_q      <= cfg_sw_on;
      sw_off_q     <= cfg_sw_off;
      im_on_q      <= cfg_im_on;
      im_off_q     <= cfg_im_off;
      num_frames_q <= cfg_num_frames;
    end
  end

  // Output stage: everything sampled from the current state/position, so the
  // whole output set lags pos by one clock and drops together after the run.
  // done fires the cycle after busy was last high, i.e. together with the
  // first all-low gate cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fs_q   <= 1'b0;
      hdr_q  <= 1'b0;
      sw_q   <= 1'b0;
      im_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      fs_q   <= run && (pos_q == '0);
      hdr_q  <= run && (pos_q < hdr_len_q);
      sw_q   <= run && (pos_q >= sw_on_q) && (pos_q < sw_off_q);
      im_q   <= run && (pos_q >= im_on_q) && (pos_q < im_off_q);
      busy_q <= (state_q != ST_IDLE);
      done_q <= busy_q && (state_q == ST_IDLE);
    end
  end

  assign frame_start = fs_q;
  assign hdr_vld     = hdr_q;
  assign fast_opsw   = sw_q;
  assign second_im   = im_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign frames_sent = frames_q;

endmodule

// File: tb/tb_frame_tx_sched.sv
// Directed bench for frame_tx_sched: bursts, continuous+stop, trigger start,
// period/window boundaries, stop on final wrap, mid-run reset.
module tb_frame_tx_sched;
  localparam int CNT_W = 16;
  localparam int NFR_W = 16;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             go = 1'b0;
  logic             stop = 1'b0;
  logic             cfg_use_trig = 1'b0;
  logic [CNT_W-1:0] cfg_period = '0;
  logic [CNT_W-1:0] cfg_hdr_len = '0;
  logic [CNT_W-1:0] cfg_sw_on = '0;
  logic [CNT_W-1:0] cfg_sw_off = '0;
  logic [CNT_W-1:0] cfg_im_on = '0;
  logic [CNT_W-1:0] cfg_im_off = '0;
  logic [NFR_W-1:0] cfg_num_frames = '0;
  logic             trig = 1'b0;
  logic             hdr_vld, fast_opsw, second_im, frame_start, busy, done;
  logic [NFR_W-1:0] frames_sent;

  int n_chk = 0;
  int n_err = 0;

  frame_tx_sched #(.CNT_W(CNT_W), .NFR_W(NFR_W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rstn(rstn), .go(go), .stop(stop),
    .cfg_use_trig(cfg_use_trig), .cfg_period(cfg_period), .cfg_hdr_len(cfg_hdr_len),
    .cfg_sw_on(cfg_sw_on), .cfg_sw_off(cfg_sw_off), .cfg_im_on(cfg_im_on),
    .cfg_im_off(cfg_im_off), .cfg_num_frames(cfg_num_frames), .trig(trig),
    .hdr_vld(hdr_vld), .fast_opsw(fast_opsw), .second_im(second_im),
    .frame_start(frame_start), .busy(busy), .done(done), .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {frame_start, hdr_vld, fast_opsw, second_im, busy, done}
  function automatic logic [5:0] ovec();
    return {frame_start, hdr_vld, fast_opsw, second_im, busy, done};
  endfunction

  task automatic set_cfg(input int p, input int hl, input int swon, input int swoff,
                         input int imon, input int imoff, input int nf, input bit ut);
    cfg_period     = CNT_W'(p);
    cfg_hdr_len    = CNT_W'(hl);
    cfg_sw_on      = CNT_W'(swon);
    cfg_sw_off     = CNT_W'(swoff);
    cfg_im_on      = CNT_W'(imon);
    cfg_im_off     = CNT_W'(imoff);
    cfg_num_frames = NFR_W'(nf);
    cfg_use_trig   = ut;
  endtask

  task automatic pulse_go();
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] e;
    int  fs_cnt, done_cnt, done_k, n;
    bit  seen;
    logic [5:0] acc;
    logic [NFR_W-1:0] acc_fr;

    // ---------------- reset state ----------------
    tick(); tick(); tick();
    check("rst_outputs", 32'(ovec()), 32'h0);
    check("rst_frames", 32'(frames_sent), 32'h0);
    rstn = 1'b1;
    tick(); tick();

    // ---------------- single burst, go+stop together (go wins) ----------------
    set_cfg(10, 3, 4, 7, 0, 10, 2, 1'b0);
    stop = 1'b1;
    pulse_go();
    stop = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      tick();
      e = {(k == 1 || k == 11),
           ((k >= 1 && k <= 3) || (k >= 11 && k <= 13)),
           ((k >= 5 && k <= 7) || (k >= 15 && k <= 17)),
           (k >= 1 && k <= 20),
           (k >= 1 && k <= 20),
           (k == 21)};
      check($sformatf("burst_k%0d", k), 32'(ovec()), 32'(e));
    end
    check("burst_frames", 32'(frames_sent), 32'd2);

    // ---------------- continuous, stop at pos 3 of frame 5, go/cfg hazard ----------------
    set_cfg(8, 2, 1, 3, 0, 0, 0, 1'b0);
    pulse_go();
    done_k = -1;
    for (int k = 1; k <= 60; k++) begin
      stop = (k == 44);
      go   = (k == 20);
      if (k == 20) cfg_period = CNT_W'(3);
      tick();
      go   = 1'b0;
      check($sformatf("cont_fs_k%0d", k), 32'(frame_start), 32'(k <= 41 && ((k - 1) % 8) == 0));
      if (done && done_k < 0) done_k = k;
      if (k == 48) check("cont_busy_last", 32'(busy), 32'd1);
    end
    stop = 1'b0;
    check("cont_done_k", 32'(done_k), 32'd49);
    check("cont_frames", 32'(frames_sent), 32'd6);
    check("cont_busy_end", 32'(busy), 32'd0);

    // ---------------- trigger start ----------------
    set_cfg(10, 3, 4, 7, 0, 10, 1, 1'b1);
    trig = 1'b0;
    pulse_go();
    acc = '0;
    for (int k = 1; k <= 50; k++) begin
      tick();
      acc = acc | {frame_start, hdr_vld, fast_opsw, second_im, 2'b00};
    end
    check("trig_no_gates", 32'(acc), 32'h0);
    check("trig_busy_wait", 32'(busy), 32'd1);
    #3 trig = 1'b1;
    n = 0;
    while (n < 20 && !frame_start) begin
      tick();
      n++;
    end
    check("trig_latency_3_4", 32'(n >= 3 && n <= 4), 32'd1);
    wait_done(40, seen);
    check("trig_done", 32'(seen), 32'd1);
    check("trig_frames", 32'(frames_sent), 32'd1);

    trig = 1'b0;
    tick(); tick(); tick(); tick();
    pulse_go();
    tick(); tick(); tick();
    check("trig2_busy", 32'(busy), 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_done(10, seen);
    check("trig2_stop_done", 32'(seen), 32'd1);
    check("trig2_frames", 32'(frames_sent), 32'd0);

    // ---------------- boundaries: period 1 and 2, empty windows, long header ----------------
    for (int t = 0; t < 2; t++) begin
      set_cfg((t == 0) ? 1 : 2, 20, 5, 5, 3, 2, 3, 1'b0);
      pulse_go();
      for (int k = 1; k <= 8; k++) begin
        tick();
        e = {(k <= 6 && (k % 2) == 1), (k <= 6), 1'b0, 1'b0, (k <= 6), (k == 7)};
        check($sformatf("bound_p%0d_k%0d", t + 1, k), 32'(ovec()), 32'(e));
      end
    end

    // ---------------- stop coinciding with the final wrap ----------------
    set_cfg(4, 1, 0, 0, 0, 0, 2, 1'b0);
    pulse_go();
    fs_cnt = 0;
    done_cnt = 0;
    done_k = -1;
    for (int k = 1; k <= 14; k++) begin
      stop = (k == 8);
      tick();
      if (frame_start) fs_cnt++;
      if (done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
    end
    stop = 1'b0;
    check("wrapstop_fs_cnt", 32'(fs_cnt), 32'd2);
    check("wrapstop_done_cnt", 32'(done_cnt), 32'd1);
    check("wrapstop_done_k", 32'(done_k), 32'd9);
    check("wrapstop_frames", 32'(frames_sent), 32'd2);

    // ---------------- mid-frame reset ----------------
    set_cfg(10, 10, 0, 10, 0, 10, 0, 1'b0);
    pulse_go();
    for (int k = 1; k <= 15; k++) tick();
    check("rst_pre_hdr", 32'(hdr_vld), 32'd1);
    check("rst_pre_frames", 32'(frames_sent), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("rst_mid_outputs", 32'(ovec()), 32'h0);
    check("rst_mid_frames", 32'(frames_sent), 32'h0);
    tick();
    rstn = 1'b1;
    acc = '0;
    acc_fr = '0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      acc = acc | ovec();
      acc_fr = acc_fr | frames_sent;
    end
    check("rst_idle_outputs", 32'(acc), 32'h0);
    check("rst_idle_frames", 32'(acc_fr), 32'h0);
    pulse_go();
    tick();
    check("rst_restart_fs", 32'(frame_start), 32'd1);
    check("rst_restart_busy", 32'(busy), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
